// File: rtl/da_exp_feeder.sv
// dA exp lane feeder: serializes one H-head dA vector into H_TILE-lane beats under credit flow control.
// Optional lane clamp (x>=+0 -> 0, so exp(x)<=1) under `DA_FEED_NEG_CLAMP_EN.
module da_exp_feeder #(
    parameter int DW      = 16,
    parameter int H       = 8,
    parameter int H_TILE  = 1,
    parameter int CREDITS = 4,
    localparam int NT     = H / H_TILE,
    localparam int TW     = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [H*DW-1:0]      in_data_i,
    output logic                 valid_o,
    output logic [H_TILE*DW-1:0] data_o,
    output logic [TW-1:0]        tile_idx_o,
    output logic                 last_o,
    input  logic                 credit_ret_i,
    output logic                 busy_o,
    output logic                 err_o
`ifdef DA_FEED_NEG_CLAMP_EN
    ,
    output logic                 clamp_seen_o
`endif
);

    localparam int BW = H_TILE * DW;
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [TW-1:0] TLAST = TW'(NT - 1);
    localparam logic [CW-1:0] CMAX  = CW'(CREDITS);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [H*DW-1:0] hold;
    logic [H*DW-1:0] in_lanes;
    logic [TW-1:0]   tile;
    logic [CW-1:0]   credit_cnt;
    logic            fire;
    logic            last_fire;
    logic            accept;

    always_comb begin
        fire       = (state == STREAM) && (credit_cnt != '0);
        last_fire  = fire && (tile == TLAST);
        // Accepting on the last-beat cycle keeps the lane stream gap-free
        in_ready_o = (state == IDLE) || last_fire;
        accept     = in_valid_i && in_ready_o;
        busy_o     = (state == STREAM);
        state_nxt  = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = STREAM;
            STREAM:  if (last_fire && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DA_FEED_NEG_CLAMP_EN
    logic any_pos;

    always_comb begin
        in_lanes = in_data_i;
        any_pos  = 1'b0;
        for (int k = 0; k < H; k++) begin
            if (!in_data_i[k*DW+DW-1]) begin
                in_lanes[k*DW +: DW] = '0;
                any_pos              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clamp_seen_o <= 1'b0;
        end else if (accept && any_pos) begin
            clamp_seen_o <= 1'b1;
        end
    end
`else
    always_comb begin
        in_lanes = in_data_i;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            tile       <= '0;
            valid_o    <= 1'b0;
            data_o     <= '0;
            tile_idx_o <= '0;
            last_o     <= 1'b0;
        end else begin
            if (accept) begin
                hold <= in_lanes;
            end
            if (accept) begin
                tile <= '0;
            end else if (fire) begin
                tile <= last_fire ? '0 : tile + 1'b1;
            end
            valid_o <= fire;
            last_o  <= last_fire;
            if (fire) begin
                data_o     <= hold[tile*BW +: BW];
                tile_idx_o <= tile;
            end
        end
    end

    // Counter mirrors free collector slots; a return at full count is a protocol error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_cnt <= CMAX;
            err_o      <= 1'b0;
        end else if (fire && !credit_ret_i) begin
            credit_cnt <= credit_cnt - 1'b1;
        end else if (!fire && credit_ret_i) begin
            if (credit_cnt == CMAX) begin
                err_o <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_da_exp_feeder.sv
// Directed bench for da_exp_feeder: two instances (CREDITS=4 and CREDITS=2), H=8, H_TILE=2.
// Clamp checks are built only with DA_FEED_NEG_CLAMP_EN defined.
module tb_da_exp_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         a_iv = 1'b0, a_ir, a_v, a_last, a_cr = 1'b0, a_busy, a_err;
    logic [127:0] a_in = '0;
    logic [31:0]  a_d;
    logic [1:0]   a_t;

    logic         b_iv = 1'b0, b_ir, b_v, b_last, b_cr = 1'b0, b_busy, b_err;
    logic [127:0] b_in = '0;
    logic [31:0]  b_d;
    logic [1:0]   b_t;

`ifdef DA_FEED_NEG_CLAMP_EN
    logic a_cs, b_cs;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    da_exp_feeder #(.DW(16), .H(8), .H_TILE(2), .CREDITS(4)) u0 (
        .clk(clk), .rst(rst),
        .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_in),
        .valid_o(a_v), .data_o(a_d), .tile_idx_o(a_t), .last_o(a_last),
        .credit_ret_i(a_cr), .busy_o(a_busy), .err_o(a_err)
`ifdef DA_FEED_NEG_CLAMP_EN
        , .clamp_seen_o(a_cs)
`endif
    );

    da_exp_feeder #(.DW(16), .H(8), .H_TILE(2), .CREDITS(2)) u1 (
        .clk(clk), .rst(rst),
        .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_in),
        .valid_o(b_v), .data_o(b_d), .tile_idx_o(b_t), .last_o(b_last),
        .credit_ret_i(b_cr), .busy_o(b_busy), .err_o(b_err)
`ifdef DA_FEED_NEG_CLAMP_EN
        , .clamp_seen_o(b_cs)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkvec(input logic [15:0] base);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[k*16 +: 16] = base + 16'(k);
        return v;
    endfunction

    function automatic logic [31:0] beat(input logic [127:0] v, input int t);
        return v[t*32 +: 32];
    endfunction

    task automatic nx;
        @(negedge clk);
    endtask

    task automatic wait_a(input int maxc, input string tag);
        int n = 0;
        while (!a_v && n < maxc) begin
            nx;
            n++;
        end
        chk({tag, "_valid"}, 64'(a_v), 64'd1);
    endtask

    task automatic wait_b(input int maxc, input string tag);
        int n = 0;
        while (!b_v && n < maxc) begin
            nx;
            n++;
        end
        chk({tag, "_valid"}, 64'(b_v), 64'd1);
    endtask

    // Accept one vector on u0 and check its four beats back to back
    task automatic run_a(input logic [127:0] vin, input logic [127:0] vexp,
                         input logic cr, input string tag);
        int n = 0;
        nx;
        a_iv = 1'b1;
        a_in = vin;
        a_cr = cr;
        while (!a_ir && n < 8) begin
            nx;
            n++;
        end
        chk({tag, "_rdy"}, 64'(a_ir), 64'd1);
        nx;
        a_iv = 1'b0;
        wait_a(4, tag);
        for (int t = 0; t < 4; t++) begin
            chk({tag, "_v"}, 64'(a_v), 64'd1);
            chk({tag, "_data"}, 64'(a_d), 64'(beat(vexp, t)));
            chk({tag, "_tile"}, 64'(a_t), 64'(t));
            chk({tag, "_last"}, 64'(a_last), 64'(t == 3));
            if (t == 3) a_cr = 1'b0;
            else nx;
        end
        nx;
        chk({tag, "_end_v"}, 64'(a_v), 64'd0);
    endtask

    logic [127:0] v0, vr, v2, va, vb;
`ifdef DA_FEED_NEG_CLAMP_EN
    logic [15:0]  cin[8]  = '{16'h3C00, 16'hBC00, 16'h0000, 16'h8000,
                              16'h7C00, 16'hFC00, 16'h3555, 16'hB555};
    logic [15:0]  cexp[8] = '{16'h0000, 16'hBC00, 16'h0000, 16'h8000,
                              16'h0000, 16'hFC00, 16'h0000, 16'hB555};
    logic [127:0] vc, vce;
`endif

    initial begin
        int acc, nb, acc_b, t3a, t0b;
        v0 = mkvec(16'hBC00);
        vr = mkvec(16'hBD10);
        v2 = mkvec(16'hBE20);
        va = mkvec(16'hB100);
        vb = mkvec(16'hC230);

        // Reset state
        nx;
        nx;
        chk("rst_valid", 64'(a_v), 64'd0);
        chk("rst_data", 64'(a_d), 64'd0);
        chk("rst_tile", 64'(a_t), 64'd0);
        chk("rst_last", 64'(a_last), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        chk("rst_b_valid", 64'(b_v), 64'd0);
        chk("rst_b_err", 64'(b_err), 64'd0);
`ifdef DA_FEED_NEG_CLAMP_EN
        chk("rst_clamp", 64'(a_cs), 64'd0);
`endif
        rst = 1'b0;
        nx;
        chk("rel_ready", 64'(a_ir), 64'd1);
        chk("rel_b_ready", 64'(b_ir), 64'd1);

        // Credit overflow on u1 while idle at full credits
        b_cr = 1'b1;
        nx;
        b_cr = 1'b0;
        chk("ovf_err", 64'(b_err), 64'd1);
        nx;
        nx;
        chk("ovf_sticky", 64'(b_err), 64'd1);
        chk("ovf_busy", 64'(b_busy), 64'd0);

        // Credit stall on u1: count stayed at 2, so exactly two beats
        nx;
        b_iv = 1'b1;
        b_in = v0;
        chk("stall_rdy", 64'(b_ir), 64'd1);
        nx;
        b_iv = 1'b0;
        wait_b(4, "stall_b0");
        chk("stall_b0_tile", 64'(b_t), 64'd0);
        chk("stall_b0_data", 64'(b_d), 64'(beat(v0, 0)));
        nx;
        chk("stall_b1_v", 64'(b_v), 64'd1);
        chk("stall_b1_tile", 64'(b_t), 64'd1);
        chk("stall_b1_data", 64'(b_d), 64'(beat(v0, 1)));
        for (int i = 0; i < 3; i++) begin
            nx;
            chk("stall_hold_v", 64'(b_v), 64'd0);
            chk("stall_hold_tile", 64'(b_t), 64'd1);
            chk("stall_busy", 64'(b_busy), 64'd1);
        end
        b_cr = 1'b1;
        nx;
        b_cr = 1'b0;
        wait_b(4, "ret1");
        chk("ret1_tile", 64'(b_t), 64'd2);
        chk("ret1_data", 64'(b_d), 64'(beat(v0, 2)));
        chk("ret1_last", 64'(b_last), 64'd0);
        nx;
        chk("ret1_single", 64'(b_v), 64'd0);
        nx;
        chk("ret1_single2", 64'(b_v), 64'd0);
        b_cr = 1'b1;
        nx;
        b_cr = 1'b0;
        wait_b(4, "ret2");
        chk("ret2_tile", 64'(b_t), 64'd3);
        chk("ret2_data", 64'(b_d), 64'(beat(v0, 3)));
        chk("ret2_last", 64'(b_last), 64'd1);
        nx;
        chk("ret2_end_v", 64'(b_v), 64'd0);
        chk("ret2_idle", 64'(b_busy), 64'd0);
        chk("ret2_ready", 64'(b_ir), 64'd1);

        // Basic serialization on u0, no returns
        run_a(v0, v0, 1'b0, "basic");
        chk("basic_idle", 64'(a_busy), 64'd0);
        chk("basic_ready", 64'(a_ir), 64'd1);

        // Credits exhausted: accepted vector must not issue
        nx;
        a_iv = 1'b1;
        a_in = vr;
        chk("nocred_rdy", 64'(a_ir), 64'd1);
        nx;
        a_iv = 1'b0;
        a_in = v0;
        for (int i = 0; i < 4; i++) begin
            nx;
            chk("nocred_v", 64'(a_v), 64'd0);
            chk("nocred_busy", 64'(a_busy), 64'd1);
        end
        chk("nocred_err", 64'(a_err), 64'd0);

        // One return -> beat 0, then reset mid-vector
        a_cr = 1'b1;
        nx;
        a_cr = 1'b0;
        wait_a(4, "rst_beat");
        chk("rst_beat_tile", 64'(a_t), 64'd0);
        chk("rst_beat_data", 64'(a_d), 64'(beat(vr, 0)));
        rst = 1'b1;
        #1;
        chk("midrst_v", 64'(a_v), 64'd0);
        chk("midrst_busy", 64'(a_busy), 64'd0);
        chk("midrst_tile", 64'(a_t), 64'd0);
        nx;
        nx;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nx;
            chk("postrst_v", 64'(a_v), 64'd0);
            chk("postrst_ready", 64'(a_ir), 64'd1);
        end
        chk("postrst_b_err", 64'(b_err), 64'd0);
        run_a(v2, v2, 1'b0, "restart");

        // Back-to-back with a return every cycle
        a_cr = 1'b1;
        acc = 0;
        nb = 0;
        acc_b = -1;
        t3a = -1;
        t0b = -100;
        for (int it = 0; it < 30 && nb < 8; it++) begin
            nx;
            if (a_v) begin
                chk("b2b_data", 64'(a_d), 64'(beat(nb < 4 ? va : vb, nb % 4)));
                chk("b2b_tile", 64'(a_t), 64'(nb % 4));
                chk("b2b_last", 64'(a_last), 64'(nb % 4 == 3));
                if (nb == 3) t3a = it;
                if (nb == 4) t0b = it;
                nb++;
            end
            if (nb == 8) a_cr = 1'b0;
            a_iv = (acc < 2);
            a_in = (acc == 0) ? va : vb;
            if (a_iv && a_ir) begin
                if (acc == 1) begin
                    acc_b = it;
                    chk("b2b_accept_busy", 64'(a_busy), 64'd1);
                end
                acc++;
            end
        end
        a_iv = 1'b0;
        a_cr = 1'b0;
        chk("b2b_count", 64'(nb), 64'd8);
        chk("b2b_accept_on_last", 64'(t3a - acc_b), 64'd1);
        chk("b2b_no_gap", 64'(t0b - t3a), 64'd1);
        nx;
        chk("b2b_end_v", 64'(a_v), 64'd0);
        chk("b2b_idle", 64'(a_busy), 64'd0);
        chk("b2b_err", 64'(a_err), 64'd0);

`ifdef DA_FEED_NEG_CLAMP_EN
        chk("pre_clamp_seen", 64'(a_cs), 64'd0);
        for (int k = 0; k < 8; k++) begin
            vc[k*16 +: 16]  = cin[k];
            vce[k*16 +: 16] = cexp[k];
        end
        run_a(vc, vce, 1'b1, "clamp");
        chk("clamp_seen", 64'(a_cs), 64'd1);
        chk("clamp_err", 64'(a_err), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/da_exp_feeder.md
Name: da_exp_feeder

Overview:
- Transmit side of the dA exp lane interface in the full-SSM datapath.
- Accepts one full H-head dA vector (dt*A, FP16 per head) over a valid/ready handshake.
- Serializes the vector into H/H_TILE beats of H_TILE lanes, driving the exp pipeline's valid/data inputs.
- The exp pipeline has no backpressure, so the feeder throttles issue with a credit counter that mirrors free slots in the downstream result collector.

Parameters:
- DW, 16, lane width (FP16 bit pattern).
- H, 8, heads per input vector; must be a multiple of H_TILE.
- H_TILE, 1, lanes per output beat; matches the exp pipeline lane count.
- CREDITS, 4, downstream slots; counter reset value and maximum.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  feeder can accept a vector.
- in_data_i  in  H*DW  dA vector; head k at bits [k*DW +: DW].
- valid_o  out  1  beat valid to the exp pipeline valid_i.
- data_o  out  H_TILE*DW  beat lanes; lane h = head t*H_TILE+h.
- tile_idx_o  out  $clog2(H/H_TILE) (min 1)  tile index of the current beat.
- last_o  out  1  current beat is tile H/H_TILE-1.
- credit_ret_i  in  1  one-cycle pulse: downstream freed one slot.
- busy_o  out  1  vector held, beats outstanding.
- err_o  out  1  sticky credit overflow flag.

Behaviour:
- NT = H/H_TILE.
- Reset: asynchronous, active-high. Clears all state:
  - state=IDLE, credit_cnt=CREDITS, tile counter=0.
  - valid_o=0, data_o=0, tile_idx_o=0, last_o=0, busy_o=0, err_o=0.
  - in_ready_o is 1 once rst deasserts.
- States:
  - IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, register in_data_i into the hold buffer, tile=0, go to STREAM.
  - STREAM: busy_o=1. A beat fires in a cycle when credit_cnt>0. On fire:
    - next cycle valid_o=1, data_o=tile t lanes, tile_idx_o=t, last_o=(t==NT-1).
    - credit_cnt decrements; tile increments.
  - With credit_cnt==0, no beat fires: next cycle valid_o=0, data_o/tile_idx_o hold their values.
- Outputs are registered. First beat appears 1 cycle after the accepting cycle at the earliest, then one beat per cycle while credits last.
- Last beat: in the cycle the last beat fires, in_ready_o=1 combinationally, so a new vector can be accepted the same cycle.
  - If accepted: stay in STREAM with tile=0, giving zero bubbles between vectors.
  - Otherwise: go to IDLE.
- valid_o is a single-cycle pulse per beat. It deasserts the cycle after the last beat unless the next vector's first beat fires.
- Credits:
  - Issue and credit_ret_i in the same cycle: credit_cnt unchanged.
  - credit_ret_i with credit_cnt==CREDITS and no issue: count saturates at CREDITS, err_o set sticky until rst.
- in_data_i is sampled only at acceptance; later changes do not affect beats in flight.
- rst mid-vector: the remaining beats are dropped, credits are restored to CREDITS, and no further valid_o is produced.
- Lane bits pass through unmodified unless the optional feature is enabled.

Optional Feature:
- Macro: DA_FEED_NEG_CLAMP_EN.
- Enabled: each lane is clamped at acceptance so exp(x)<=1.
  - Sign bit 0 (x>=+0, including +Inf and positive NaN) is replaced with 16'h0000.
  - Sign bit 1 passes unchanged.
  - Sticky output clamp_seen_o (1 bit, reset 0) sets when any lane is clamped.
- Disabled: no clamping, and port clamp_seen_o does not exist.

Test Plan:
- Basic serialization, H=8, H_TILE=2, CREDITS=4, in_data_i heads 0..7 = 16'hBC00+k, credit_ret_i tied 0:
  - Beats 1 cycle after accept: {BC01,BC00}, {BC03,BC02}, {BC05,BC04}, {BC07,BC06}.
  - tile_idx_o 0..3, last_o only on the 4th beat, then credit_cnt=0.
- Credit stall, CREDITS=2, same vector: 2 beats, then valid_o=0.
  - Pulse credit_ret_i once -> exactly one beat (tile 2) the next cycle.
  - Pulse again -> tile 3 with last_o=1, then IDLE.
- Back-to-back, credit_ret_i pulsed every cycle, in_valid_i held with a second vector:
  - in_ready_o=1 on the last-beat cycle.
  - Second vector's tile 0 follows the first vector's tile 3 with no gap.
- Credit overflow: credit_ret_i pulsed in IDLE with credit_cnt=CREDITS -> err_o=1 and stays 1; credit_cnt remains CREDITS.
- Reset mid-stream: assert rst after beat 1 of 4 -> valid_o=0 immediately, no further beats; after release, in_ready_o=1 and a new vector streams from tile 0 with full credits.
- With DA_FEED_NEG_CLAMP_EN, heads {3C00, BC00, 0000, 8000, 7C00, FC00, 3555, B555}:
  - Beats carry {0000, BC00, 0000, 8000, 0000, FC00, 0000, B555}.
  - clamp_seen_o=1.
